stk_pipe_adm: RTL and testbench

Parametrised admission/dispatch stage at the head of the stack pipeline. It arbitrates per-engine PUSH/POP/INV commands into per-class FIFOs and enforces one command per engine from acceptance until response. It issues at most one command per cycle to the LK stage and requests a line from the AL stage for every PUSH. It generalises engine count, data width and queue depth, and makes INV a fully serviced class.

---
 rtl/stk_pipe_adm.sv | 218 +++++++++++++++++++++
 tb/tb_stk_pipe_adm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stk_pipe_adm.sv
// Admission/dispatch stage: round-robin enqueue of per-engine PUSH/POP/INV commands into
// per-class FIFOs, round-robin issue to LK. Define STK_PIPE_ADM_PERF_EN for issue/stall counters.
package stk_pkg;
    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_INV  = 2'd3
    } opcode_t;
endpackage

module stk_pipe_adm #(
    parameter int ENGS_N  = 4,
    parameter int DAT_W   = 128,
    parameter int Q_DEPTH = 2,
    parameter int ENGID_W = $clog2(ENGS_N)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  stk_pkg::opcode_t [ENGS_N-1:0]     i_cmd_opcode,
    input  logic [ENGS_N-1:0][DAT_W-1:0]      i_cmd_dat,
    output logic [ENGS_N-1:0]                 o_cmd_ack,
    output logic                              o_lk_vld_w,
    output logic [ENGID_W-1:0]                o_lk_engid_w,
    output stk_pkg::opcode_t                  o_lk_opcode_w,
    output logic                              o_lk_dat_vld_w,
    output logic [DAT_W-1:0]                  o_lk_dat_w,
    input  logic                              i_al_empty_r,
    input  logic                              i_al_busy_r,
    output logic                              o_al_alloc,
    input  logic [ENGS_N-1:0]                 i_rsp_vld,
    output logic [ENGS_N-1:0]                 o_busy_r,
    output logic [2:0]                        o_q_full_r
`ifdef STK_PIPE_ADM_PERF_EN
    ,
    output logic [2:0][31:0]                  o_perf_issue_r,
    output logic [31:0]                       o_perf_stall_r
`endif
);
    import stk_pkg::*;

    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        CLS_PUSH = 2'd0,
        CLS_POP  = 2'd1,
        CLS_INV  = 2'd2
    } cls_t;

    logic [ENGS_N-1:0]  busy_r, active_r;
    logic [ENGID_W-1:0] enq_ptr;
    logic [1:0]         deq_ptr;

    logic [ENGID_W-1:0] q_eng [3][Q_DEPTH];
    logic [DAT_W-1:0]   q_dat [Q_DEPTH];
    logic [PTR_W-1:0]   wr_ptr [3];
    logic [PTR_W-1:0]   rd_ptr [3];
    logic [CNT_W-1:0]   cnt [3];
    logic [CNT_W-1:0]   cnt_nxt [3];
    logic [2:0]         full_r, empty_r;

    logic [ENGS_N-1:0]  req_vld, enq_req;
    logic [1:0]         req_cls [ENGS_N];
    int unsigned        enq_idx;
    logic               enq_any, enq_ack;
    logic [ENGID_W-1:0] enq_win, enq_nxt;
    logic [1:0]         enq_cls;

    logic [ENGID_W-1:0] head_eng [3];
    logic [2:0]         elig, wr, rd;
    int unsigned        deq_idx;
    logic               deq_any, deq_ack;
    logic [1:0]         deq_win, deq_nxt;
    logic [ENGID_W-1:0] deq_eng;

    logic [ENGS_N-1:0]  rsp_clr, set_act;

    // Enqueue: decode, per-engine request, round-robin grant
    always_comb begin
        enq_req = '0;
        req_vld = '0;
        for (int unsigned e = 0; e < ENGS_N; e++) begin
            req_cls[e] = CLS_PUSH;
            case (i_cmd_opcode[e])
                OP_PUSH: begin req_vld[e] = 1'b1; req_cls[e] = CLS_PUSH; end
                OP_POP:  begin req_vld[e] = 1'b1; req_cls[e] = CLS_POP;  end
                OP_INV:  begin req_vld[e] = 1'b1; req_cls[e] = CLS_INV;  end
                default: ;
            endcase
            enq_req[e] = req_vld[e] & ~busy_r[e] & ~full_r[req_cls[e]];
        end
    end

    always_comb begin
        enq_any = 1'b0;
        enq_win = '0;
        enq_idx = 0;
        for (int unsigned k = 0; k < ENGS_N; k++) begin
            enq_idx = (32'(enq_ptr) + k) % ENGS_N;
            if (!enq_any && enq_req[enq_idx]) begin
                enq_any = 1'b1;
                enq_win = ENGID_W'(enq_idx);
            end
        end
        enq_ack = enq_any & ~rst;
        enq_nxt = (enq_win == ENGID_W'(ENGS_N - 1)) ? '0 : enq_win + 1'b1;
        enq_cls = req_cls[enq_win];
        o_cmd_ack = '0;
        if (enq_ack) o_cmd_ack[enq_win] = 1'b1;
    end

    // Dequeue: per-class eligibility, round-robin over PUSH/POP/INV
    always_comb begin
        deq_any = 1'b0;
        deq_win = CLS_PUSH;
        deq_idx = 0;
        for (int unsigned c = 0; c < 3; c++) begin
            head_eng[c] = q_eng[c][rd_ptr[c]];
            elig[c]     = ~empty_r[c] & ~active_r[head_eng[c]];
        end
        elig[CLS_PUSH] = elig[CLS_PUSH] & ~i_al_empty_r;
        for (int unsigned k = 0; k < 3; k++) begin
            deq_idx = 32'(deq_ptr) + k;
            if (deq_idx >= 3) deq_idx = deq_idx - 3;
            if (!deq_any && elig[deq_idx]) begin
                deq_any = 1'b1;
                deq_win = 2'(deq_idx);
            end
        end
        deq_ack = deq_any & ~i_al_busy_r & ~rst;
        deq_nxt = (deq_win == CLS_INV) ? CLS_PUSH : deq_win + 2'd1;
        deq_eng = head_eng[deq_win];
    end

    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            wr[c]      = enq_ack & (enq_cls == 2'(c));
            rd[c]      = deq_ack & (deq_win == 2'(c));
            cnt_nxt[c] = cnt[c] + CNT_W'(wr[c]) - CNT_W'(rd[c]);
        end
        rsp_clr = i_rsp_vld & busy_r;
        set_act = '0;
        if (deq_ack) set_act[deq_eng] = 1'b1;
    end

    always_comb begin
        o_lk_vld_w     = deq_ack;
        o_lk_engid_w   = deq_ack ? deq_eng : '0;
        o_lk_opcode_w  = OP_NOP;
        if (deq_ack) begin
            case (deq_win)
                CLS_PUSH: o_lk_opcode_w = OP_PUSH;
                CLS_POP:  o_lk_opcode_w = OP_POP;
                CLS_INV:  o_lk_opcode_w = OP_INV;
                default:  o_lk_opcode_w = OP_NOP;
            endcase
        end
        o_lk_dat_vld_w = deq_ack & (deq_win == CLS_PUSH);
        o_lk_dat_w     = o_lk_dat_vld_w ? q_dat[rd_ptr[CLS_PUSH]] : '0;
        o_al_alloc     = o_lk_dat_vld_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enq_ptr  <= '0;
            deq_ptr  <= CLS_PUSH;
            busy_r   <= '0;
            active_r <= '0;
            full_r   <= '0;
            empty_r  <= '1;
            for (int unsigned c = 0; c < 3; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
        end else begin
            if (enq_ack) enq_ptr <= enq_nxt;
            if (deq_ack) deq_ptr <= deq_nxt;
            // Response clear takes priority over any same-cycle set
            busy_r   <= (busy_r | o_cmd_ack) & ~rsp_clr;
            active_r <= (active_r | set_act) & ~rsp_clr;
            for (int unsigned c = 0; c < 3; c++) begin
                if (wr[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (rd[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
                cnt[c]     <= cnt_nxt[c];
                full_r[c]  <= (cnt_nxt[c] == CNT_W'(Q_DEPTH));
                empty_r[c] <= (cnt_nxt[c] == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < 3; c++) begin
            if (wr[c]) q_eng[c][wr_ptr[c]] <= enq_win;
        end
        if (wr[CLS_PUSH]) q_dat[wr_ptr[CLS_PUSH]] <= i_cmd_dat[enq_win];
    end

    assign o_busy_r   = busy_r;
    assign o_q_full_r = full_r;

`ifdef STK_PIPE_ADM_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_perf_issue_r <= '0;
            o_perf_stall_r <= '0;
        end else begin
            for (int unsigned c = 0; c < 3; c++) begin
                if (rd[c] && o_perf_issue_r[c] != '1) o_perf_issue_r[c] <= o_perf_issue_r[c] + 32'd1;
            end
            if ((|(~empty_r)) && !deq_ack && o_perf_stall_r != '1)
                o_perf_stall_r <= o_perf_stall_r + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stk_pipe_adm.sv
// Scoreboard bench for stk_pipe_adm: directed stimulus pushes expected LK issues,
// a forked monitor pops and compares on every o_lk_vld_w.
module tb_stk_pipe_adm;
    import stk_pkg::*;

    logic                  clk;
    logic                  rst;
    opcode_t [3:0]         op;
    logic [3:0][127:0]     dat;
    logic [3:0]            ack;
    logic                  lk_vld;
    logic [1:0]            lk_engid;
    opcode_t               lk_op;
    logic                  lk_dat_vld;
    logic [127:0]          lk_dat;
    logic                  al_empty, al_busy, al_alloc;
    logic [3:0]            rsp, busy;
    logic [2:0]            qfull;

    stk_pipe_adm #(.ENGS_N(4), .DAT_W(128), .Q_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_opcode(op), .i_cmd_dat(dat), .o_cmd_ack(ack),
        .o_lk_vld_w(lk_vld), .o_lk_engid_w(lk_engid), .o_lk_opcode_w(lk_op),
        .o_lk_dat_vld_w(lk_dat_vld), .o_lk_dat_w(lk_dat),
        .i_al_empty_r(al_empty), .i_al_busy_r(al_busy), .o_al_alloc(al_alloc),
        .i_rsp_vld(rsp), .o_busy_r(busy), .o_q_full_r(qfull)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   engid;
        opcode_t      op;
        logic [127:0] dat;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic [3:0] ack_s, busy_s;
    logic [2:0] full_s;
    logic       vld_s;
    logic       auto_rsp;
    logic [3:0] hold;
    logic [5:0] v3;
    logic [3:0] a4 [7];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] e, input opcode_t o, input logic [127:0] d);
        exp_t x;
        x.engid = e; x.op = o; x.dat = d;
        exp_q.push_back(x);
    endtask

    task automatic monitor();
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst && lk_vld) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL issue_unexpected: got engid %0d op %0d want none", lk_engid, lk_op);
                end else begin
                    x = exp_q.pop_front();
                    chk("issue_engid", 128'(lk_engid), 128'(x.engid));
                    chk("issue_op", 128'(lk_op), 128'(x.op));
                    chk("issue_dat", lk_dat, (x.op == OP_PUSH) ? x.dat : 128'h0);
                    chk("issue_dat_vld", 128'(lk_dat_vld), 128'(x.op == OP_PUSH));
                    chk("issue_alloc", 128'(al_alloc), 128'(x.op == OP_PUSH));
                end
            end
        end
    endtask

    // One cycle: sample mid-cycle, advance past the edge, then update engines and responses
    task automatic step();
        logic [3:0] rsp_nxt;
        @(negedge clk);
        ack_s  = ack;
        vld_s  = lk_vld;
        busy_s = busy;
        full_s = qfull;
        rsp_nxt = '0;
        if (auto_rsp && lk_vld && !rst) rsp_nxt[lk_engid] = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 0; e < 4; e++) if (ack_s[e] && !hold[e]) op[e] = OP_NOP;
        rsp = rsp_nxt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        for (int e = 0; e < 4; e++) op[e] = OP_NOP;
        dat = '0; rsp = '0; al_empty = 1'b0; al_busy = 1'b0;
        auto_rsp = 1'b0; hold = '0;
        fork monitor(); join_none

        // Reset: outputs forced low even with a request pending
        op[0] = OP_PUSH; dat[0] = 128'h11;
        repeat (2) step();
        chk("rst_ack", 128'(ack_s), 128'h0);
        chk("rst_vld", 128'(vld_s), 128'h0);
        chk("rst_busy", 128'(busy_s), 128'h0);
        chk("rst_full", 128'(full_s), 128'h0);
        rst = 1'b0; op[0] = OP_NOP;

        // Single PUSH
        op[2] = OP_PUSH; dat[2] = 128'hA5;
        push_exp(2'd2, OP_PUSH, 128'hA5);
        step();
        chk("t1_ack", 128'(ack_s), 128'h4);
        chk("t1_busy_t", 128'(busy_s), 128'h0);
        step();
        chk("t1_vld_t1", 128'(vld_s), 128'h1);
        chk("t1_busy_t1", 128'(busy_s), 128'h4);
        step();
        chk("t1_vld_t2", 128'(vld_s), 128'h0);
        chk("t1_busy_hold", 128'(busy_s), 128'h4);
        rsp[2] = 1'b1;
        step();
        step();
        chk("t1_busy_clr", 128'(busy_s), 128'h0);

        // Fairness: four engines POP continuously
        do_reset();
        auto_rsp = 1'b1; hold = 4'hF;
        for (int e = 0; e < 4; e++) op[e] = OP_POP;
        for (int k = 0; k < 8; k++) push_exp(2'(k % 4), OP_POP, 128'h0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_ack_order", 128'(ack_s), 128'(4'b0001 << (k % 4)));
        end
        hold = '0;
        for (int e = 0; e < 4; e++) op[e] = OP_NOP;
        repeat (4) step();
        chk("t2_busy_idle", 128'(busy_s), 128'h0);

        // Hazard: PUSH blocked by empty free list, POP overtakes
        al_empty = 1'b1;
        op[1] = OP_PUSH; dat[1] = 128'hD1; op[3] = OP_POP;
        push_exp(2'd3, OP_POP, 128'h0);
        push_exp(2'd1, OP_PUSH, 128'hD1);
        v3 = 6'b100100;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) al_empty = 1'b0;
            step();
            chk("t3_vld", 128'(vld_s), 128'(v3[k]));
        end
        repeat (3) step();

        // Full: downstream stall, third PUSH held until a pop
        al_busy = 1'b1;
        op[0] = OP_PUSH; dat[0] = 128'hC0;
        op[1] = OP_PUSH; dat[1] = 128'hC1;
        op[2] = OP_PUSH; dat[2] = 128'hC2;
        push_exp(2'd0, OP_PUSH, 128'hC0);
        push_exp(2'd1, OP_PUSH, 128'hC1);
        push_exp(2'd2, OP_PUSH, 128'hC2);
        a4[0] = 4'b0001; a4[1] = 4'b0010; a4[2] = 4'b0000; a4[3] = 4'b0000;
        a4[4] = 4'b0000; a4[5] = 4'b0000; a4[6] = 4'b0100;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) al_busy = 1'b0;
            step();
            chk("t4_ack", 128'(ack_s), 128'(a4[k]));
            if (k == 2) begin
                chk("t4_full", 128'(full_s), 128'h1);
                chk("t4_stall_vld", 128'(vld_s), 128'h0);
            end
        end
        repeat (4) step();

        // INV with response colliding with a new request
        auto_rsp = 1'b0;
        op[0] = OP_INV;
        push_exp(2'd0, OP_INV, 128'h0);
        push_exp(2'd0, OP_INV, 128'h0);
        step();
        chk("t5_ack0", 128'(ack_s), 128'h1);
        step();
        chk("t5_vld0", 128'(vld_s), 128'h1);
        rsp[0] = 1'b1; op[0] = OP_INV;
        step();
        chk("t5_ack_collide", 128'(ack_s), 128'h0);
        step();
        chk("t5_ack_after", 128'(ack_s), 128'h1);
        step();
        chk("t5_vld1", 128'(vld_s), 128'h1);
        rsp[0] = 1'b1;
        step();
        step();
        chk("t5_busy", 128'(busy_s), 128'h0);

        // Reset mid-stream with two queued POPs
        al_busy = 1'b1;
        op[1] = OP_POP; op[2] = OP_POP;
        step();
        chk("t6_ack_a", 128'(ack_s), 128'h2);
        step();
        chk("t6_ack_b", 128'(ack_s), 128'h4);
        step();
        chk("t6_full", 128'(full_s), 128'h2);
        rst = 1'b1; al_busy = 1'b0;
        step();
        chk("t6_vld_in_rst", 128'(vld_s), 128'h0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_vld_after", 128'(vld_s), 128'h0);
        end
        chk("t6_busy", 128'(busy_s), 128'h0);
        chk("t6_full_clr", 128'(full_s), 128'h0);
        auto_rsp = 1'b1;
        op[1] = OP_POP;
        push_exp(2'd1, OP_POP, 128'h0);
        step();
        chk("t6_fresh_ack", 128'(ack_s), 128'h2);
        step();
        chk("t6_fresh_vld", 128'(vld_s), 128'h1);
        repeat (3) step();

        chk("sb_drain", 128'(exp_q.size()), 128'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
